// File: rtl/generador_tono_frecuencia_if.sv
//==============================================================================
// Module      : generador_tono_frecuencia_if
// Description : Control and status bundle of the square-wave tone generator.
//               master: frequency selector side (drives EN/f, reads status).
//               slave : tone generator side.
//   EN          run request, level-sensitive
//   f[5:0]      requested frequency code k (0 = silence)
//   sq_out      square-wave output
//   f_activa    code currently driving sq_out
//   period_tick one-clk pulse per completed period
//   busy        generator is running
//   cambio_pend running with f different from f_activa
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface generador_tono_frecuencia_if;
  logic       EN;
  logic [5:0] f;
  logic       sq_out;
  logic [5:0] f_activa;
  logic       period_tick;
  logic       busy;
  logic       cambio_pend;

  modport master (
    output EN, f,
    input  sq_out, f_activa, period_tick, busy, cambio_pend
  );

  modport slave (
    input  EN, f,
    output sq_out, f_activa, period_tick, busy, cambio_pend
  );
endinterface

`default_nettype wire

// File: rtl/generador_tono_frecuencia.sv
//==============================================================================
// Module      : generador_tono_frecuencia
// Description : 50 % duty square-wave generator. Half-period is
//               f_activa * PRESCALE clk cycles. A new code is only adopted at
//               a full-period boundary, and a stop request lets the current
//               period finish, so the output never carries runt pulses.
// Ports       : clk  - system clock (rising edge)
//               rst  - asynchronous reset, active low
//               bus  - generador_tono_frecuencia_if.slave (EN, f in;
//                      sq_out, f_activa, period_tick, busy, cambio_pend out)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module generador_tono_frecuencia #(
  parameter int PRESCALE = 25000,
  parameter int PRE_W    = 16
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  generador_tono_frecuencia_if.slave     bus
);

  localparam logic [0:0]       ST_IDLE    = 1'b0;
  localparam logic [0:0]       ST_RUN     = 1'b1;
  localparam logic [PRE_W-1:0] c_PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [5:0]       r_half_cnt;
  logic             r_sq;
  logic [5:0]       r_f_activa;
  logic             r_tick;

  logic w_start;
  logic w_base_tick;
  logic w_half_end;
  logic w_period_end;
  logic w_stop_req;

  // f_activa is never 0 while running, so f_activa-1 cannot wrap here.
  assign w_start      = (r_state == ST_IDLE) && bus.EN && (bus.f != 6'd0);
  assign w_base_tick  = (r_state == ST_RUN) && (r_pre_cnt == c_PRE_LAST);
  assign w_half_end   = w_base_tick && (r_half_cnt == (r_f_activa - 6'd1));
  assign w_period_end = w_half_end && !r_sq;
  assign w_stop_req   = !bus.EN || (bus.f == 6'd0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start)                   w_state_nxt = ST_RUN;
      ST_RUN:  if (w_period_end && w_stop_req) w_state_nxt = ST_IDLE;
      default:                                w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic (status flags)
  always_comb begin
    bus.busy        = (r_state == ST_RUN);
    bus.cambio_pend = (r_state == ST_RUN) && (bus.f != r_f_activa);
  end

  // Timing datapath: prescaler, half-period counter, output level and code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre_cnt  <= '0;
      r_half_cnt <= 6'd0;
      r_sq       <= 1'b0;
      r_f_activa <= 6'd0;
      r_tick     <= 1'b0;
    end else begin
      r_tick <= w_period_end;
      if (r_state == ST_IDLE) begin
        r_pre_cnt  <= '0;
        r_half_cnt <= 6'd0;
        if (w_start) begin
          r_sq       <= 1'b1;
          r_f_activa <= bus.f;
        end else begin
          r_sq       <= 1'b0;
        end
      end else begin
        r_pre_cnt <= w_base_tick ? '0 : r_pre_cnt + 1'b1;
        if (w_half_end) begin
          r_half_cnt <= 6'd0;
        end else if (w_base_tick) begin
          r_half_cnt <= r_half_cnt + 6'd1;
        end
        if (w_half_end) begin
          if (r_sq) begin
            r_sq <= 1'b0;
          end else if (!w_stop_req) begin
            // Period boundary: the code present at this edge takes effect.
            r_sq       <= 1'b1;
            r_f_activa <= bus.f;
          end
        end
      end
    end
  end

  assign bus.sq_out      = r_sq;
  assign bus.f_activa    = r_f_activa;
  assign bus.period_tick = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_generador_tono_frecuencia.sv
`default_nettype none

module tb_generador_tono_frecuencia;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  generador_tono_frecuencia_if bus0 ();
  generador_tono_frecuencia_if bus1 ();

  // Instance 0 uses PRESCALE=2, instance 1 uses PRESCALE=1.
  generador_tono_frecuencia #(.PRESCALE(2), .PRE_W(16)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  generador_tono_frecuencia #(.PRESCALE(1), .PRE_W(4)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  logic       en_d [2];
  logic [5:0] f_d  [2];
  assign bus0.EN = en_d[0];
  assign bus0.f  = f_d[0];
  assign bus1.EN = en_d[1];
  assign bus1.f  = f_d[1];

  int checks = 0;
  int errors = 0;

  function automatic int presc(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Reference model: tracks how many cycles remain in the current half-period.
  logic       m_run  [2];
  logic       m_sq   [2];
  logic       m_tick [2];
  logic [5:0] m_fa   [2];
  int         m_rem  [2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] <= 1'b0; m_sq[i] <= 1'b0; m_tick[i] <= 1'b0;
        m_fa[i] <= 6'd0; m_rem[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_tick[i] <= 1'b0;
        if (!m_run[i]) begin
          if (en_d[i] && f_d[i] != 6'd0) begin
            m_run[i] <= 1'b1; m_sq[i] <= 1'b1; m_fa[i] <= f_d[i];
            m_rem[i] <= int'(f_d[i]) * presc(i);
          end
        end else if (m_rem[i] > 1) begin
          m_rem[i] <= m_rem[i] - 1;
        end else if (m_sq[i]) begin
          m_sq[i]  <= 1'b0;
          m_rem[i] <= int'(m_fa[i]) * presc(i);
        end else begin
          m_tick[i] <= 1'b1;
          if (!en_d[i] || f_d[i] == 6'd0) begin
            m_run[i] <= 1'b0;
          end else begin
            m_fa[i]  <= f_d[i]; m_sq[i] <= 1'b1;
            m_rem[i] <= int'(f_d[i]) * presc(i);
          end
        end
      end
    end
  end

  // Packed views {sq_out, f_activa, period_tick, busy, cambio_pend}
  logic [9:0] obs0, obs1, exp0, exp1;
  assign obs0 = {bus0.sq_out, bus0.f_activa, bus0.period_tick, bus0.busy, bus0.cambio_pend};
  assign obs1 = {bus1.sq_out, bus1.f_activa, bus1.period_tick, bus1.busy, bus1.cambio_pend};
  assign exp0 = {m_sq[0], m_fa[0], m_tick[0], m_run[0], m_run[0] && (f_d[0] != m_fa[0])};
  assign exp1 = {m_sq[1], m_fa[1], m_tick[1], m_run[1], m_run[1] && (f_d[1] != m_fa[1])};

  task automatic test_reset();
    en_d[0] = 1'b1; f_d[0] = 6'd5;
    en_d[1] = 1'b1; f_d[1] = 6'd5;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs0 !== 10'd0 || obs1 !== 10'd0) begin
      errors++; $display("FAIL reset_state got %h/%h exp 000/000", obs0, obs1);
    end
    en_d[0] = 1'b0; f_d[0] = 6'd0;
    en_d[1] = 1'b0; f_d[1] = 6'd0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs0 !== 10'd0 || obs1 !== 10'd0) begin
      errors++; $display("FAIL idle_after_reset got %h/%h exp 000/000", obs0, obs1);
    end
  endtask

  // Starts instance 0 with f=3 from IDLE and measures one full period.
  task automatic test_basic(input string tag);
    int hi, lo;
    en_d[0] = 1'b1; f_d[0] = 6'd3;
    @(negedge clk);
    checks++;
    if (bus0.sq_out !== 1'b1 || bus0.busy !== 1'b1 || bus0.f_activa !== 6'd3) begin
      errors++; $display("FAIL %s_start sq=%b busy=%b fa=%0d exp 1 1 3", tag,
                         bus0.sq_out, bus0.busy, bus0.f_activa);
    end
    hi = 0;
    while (bus0.sq_out === 1'b1 && hi < 50) begin hi++; @(negedge clk); end
    lo = 0;
    while (bus0.sq_out === 1'b0 && lo < 50) begin
      if (bus0.period_tick !== 1'b0) begin
        checks++; errors++; $display("FAIL %s_early_tick at low %0d got 1 exp 0", tag, lo);
      end
      lo++; @(negedge clk);
    end
    checks++;
    if (hi != 6 || lo != 6) begin
      errors++; $display("FAIL %s_phase_len got hi=%0d lo=%0d exp 6 6", tag, hi, lo);
    end
    checks++;
    if (bus0.period_tick !== 1'b1 || bus0.f_activa !== 6'd3 || bus0.busy !== 1'b1) begin
      errors++; $display("FAIL %s_period_tick tick=%b fa=%0d busy=%b exp 1 3 1", tag,
                         bus0.period_tick, bus0.f_activa, bus0.busy);
    end
    @(negedge clk);
    checks++;
    if (bus0.period_tick !== 1'b0) begin
      errors++; $display("FAIL %s_tick_width got 1 exp 0", tag);
    end
  endtask

  // Entered at the 2nd high cycle of an f=3 period.
  task automatic test_change();
    int h1, l1, h2, l2;
    f_d[0] = 6'd5;
    #1;
    checks++;
    if (bus0.cambio_pend !== 1'b1 || bus0.f_activa !== 6'd3) begin
      errors++; $display("FAIL change_pend got pend=%b fa=%0d exp 1 3",
                         bus0.cambio_pend, bus0.f_activa);
    end
    h1 = 0; while (bus0.sq_out === 1'b1 && h1 < 50) begin h1++; @(negedge clk); end
    l1 = 0; while (bus0.sq_out === 1'b0 && l1 < 50) begin l1++; @(negedge clk); end
    checks++;
    if (h1 != 5 || l1 != 6) begin
      errors++; $display("FAIL change_old_period got hi=%0d lo=%0d exp 5 6", h1, l1);
    end
    checks++;
    if (bus0.f_activa !== 6'd5 || bus0.cambio_pend !== 1'b0 || bus0.period_tick !== 1'b1) begin
      errors++; $display("FAIL change_apply fa=%0d pend=%b tick=%b exp 5 0 1",
                         bus0.f_activa, bus0.cambio_pend, bus0.period_tick);
    end
    h2 = 0; while (bus0.sq_out === 1'b1 && h2 < 50) begin h2++; @(negedge clk); end
    l2 = 0; while (bus0.sq_out === 1'b0 && l2 < 50) begin l2++; @(negedge clk); end
    checks++;
    if (h2 != 10 || l2 != 10) begin
      errors++; $display("FAIL change_new_period got hi=%0d lo=%0d exp 10 10", h2, l2);
    end
  endtask

  task automatic test_graceful_stop();
    int k, lo;
    f_d[0] = 6'd2;
    k = 0; while (bus0.f_activa !== 6'd2 && k < 60) begin k++; @(negedge clk); end
    k = 0; while (bus0.sq_out === 1'b1 && k < 60) begin k++; @(negedge clk); end
    lo = 0;
    for (int n = 0; n < 50; n++) begin
      if (bus0.period_tick === 1'b1) break;
      if (n == 1) en_d[0] = 1'b0;
      lo++;
      @(negedge clk);
    end
    checks++;
    if (lo != 4 || bus0.period_tick !== 1'b1 || bus0.busy !== 1'b0 || bus0.sq_out !== 1'b0) begin
      errors++; $display("FAIL stop_end lo=%0d tick=%b busy=%b sq=%b exp 4 1 0 0",
                         lo, bus0.period_tick, bus0.busy, bus0.sq_out);
    end
    checks++;
    if (bus0.f_activa !== 6'd2) begin
      errors++; $display("FAIL stop_fa got %0d exp 2", bus0.f_activa);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus0.busy !== 1'b0 || bus0.sq_out !== 1'b0 || bus0.period_tick !== 1'b0) begin
      errors++; $display("FAIL stop_idle busy=%b sq=%b tick=%b exp 0 0 0",
                         bus0.busy, bus0.sq_out, bus0.period_tick);
    end
  endtask

  task automatic test_silence();
    int k;
    en_d[0] = 1'b1; f_d[0] = 6'd0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checks++;
      if (bus0.sq_out !== 1'b0 || bus0.busy !== 1'b0 || bus0.period_tick !== 1'b0) begin
        errors++; $display("FAIL silence_idle cyc %0d sq=%b busy=%b tick=%b exp 0 0 0",
                           n, bus0.sq_out, bus0.busy, bus0.period_tick);
      end
    end
    f_d[0] = 6'd4;
    repeat (3) @(negedge clk);
    f_d[0] = 6'd0;
    #1;
    checks++;
    if (bus0.cambio_pend !== 1'b1 || bus0.busy !== 1'b1) begin
      errors++; $display("FAIL silence_pend pend=%b busy=%b exp 1 1", bus0.cambio_pend, bus0.busy);
    end
    k = 0;
    while (bus0.period_tick !== 1'b1 && k < 60) begin k++; @(negedge clk); end
    checks++;
    if (k != 14 || bus0.busy !== 1'b0 || bus0.sq_out !== 1'b0) begin
      errors++; $display("FAIL silence_stop wait=%0d busy=%b sq=%b exp 14 0 0",
                         k, bus0.busy, bus0.sq_out);
    end
  endtask

  task automatic test_prescale_one();
    int k, hi, lo;
    logic bad;
    en_d[1] = 1'b1; f_d[1] = 6'd1;
    bad = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus1.sq_out !== ((n % 2) == 0) ||
          bus1.period_tick !== (n >= 2 && (n % 2) == 0)) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL p1_toggle got sq=%b tick=%b at last cycle exp alternating",
                         bus1.sq_out, bus1.period_tick);
    end
    f_d[1] = 6'd63;
    k = 0; while (bus1.f_activa !== 6'd63 && k < 10) begin k++; @(negedge clk); end
    hi = 0; while (bus1.sq_out === 1'b1 && hi < 200) begin hi++; @(negedge clk); end
    lo = 0; while (bus1.sq_out === 1'b0 && lo < 200) begin lo++; @(negedge clk); end
    checks++;
    if (hi != 63 || lo != 63 || bus1.period_tick !== 1'b1) begin
      errors++; $display("FAIL p1_k63 hi=%0d lo=%0d tick=%b exp 63 63 1", hi, lo, bus1.period_tick);
    end
    en_d[1] = 1'b0;
  endtask

  task automatic test_async_reset();
    int k;
    en_d[0] = 1'b1; f_d[0] = 6'd3;
    k = 0; while (bus0.sq_out !== 1'b1 && k < 60) begin k++; @(negedge clk); end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus0.sq_out !== 1'b0 || bus0.f_activa !== 6'd0 || bus0.busy !== 1'b0 ||
        bus0.period_tick !== 1'b0) begin
      errors++; $display("FAIL async_reset sq=%b fa=%0d busy=%b tick=%b exp 0 0 0 0",
                         bus0.sq_out, bus0.f_activa, bus0.busy, bus0.period_tick);
    end
    en_d[0] = 1'b0; f_d[0] = 6'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_basic("restart");
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      checks++;
      if (obs0 !== exp0) begin
        errors++; $display("FAIL rand_p2 cyc %0d got %h exp %h", n, obs0, exp0);
      end
      checks++;
      if (obs1 !== exp1) begin
        errors++; $display("FAIL rand_p1 cyc %0d got %h exp %h", n, obs1, exp1);
      end
      if ($urandom_range(0, 9) == 0) en_d[0] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) f_d[0]  = 6'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) en_d[1] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) f_d[1]  = 6'($urandom_range(0, 6));
    end
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_change();
    test_graceful_stop();
    test_silence();
    test_prescale_one();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
